// File: rtl/dmem_host_ctrl.sv
// Host-side sequencer for port B of the MEM-stage data BRAM: single writes,
// fill bursts and read bursts, one access per cycle, locked out while the pipeline runs.
module dmem_host_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_active,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  dmem_prog_en,
    output logic                  dmem_prog_we,
    output logic [ADDR_WIDTH-1:0] dmem_prog_addr,
    output logic [DATA_WIDTH-1:0] dmem_prog_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_prog_rdata
);

    typedef enum logic [2:0] {IDLE, WRITE, FILL, READ, DRAIN} state_t;

    localparam logic [1:0]           OP_READ  = 2'd0;
    localparam logic [1:0]           OP_WRITE = 2'd1;
    localparam logic [1:0]           OP_FILL  = 2'd2;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN  = LEN_WIDTH'(1 << ADDR_WIDTH);

    state_t                  state;
    logic [LEN_WIDTH-1:0]    remain;
    logic                    vld_p1;
    logic [ADDR_WIDTH-1:0]   addr_p1;
    logic                    accept;

    function automatic logic cmd_legal(input logic [1:0] op, input logic [LEN_WIDTH-1:0] len);
        case (op)
            OP_WRITE:         cmd_legal = 1'b1;
            OP_READ, OP_FILL: cmd_legal = (len != '0) && (len <= MAX_LEN);
            default:          cmd_legal = 1'b0;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE) && !pipe_active && !reset;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            remain          <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            dmem_prog_en    <= 1'b0;
            dmem_prog_we    <= 1'b0;
            dmem_prog_addr  <= '0;
            dmem_prog_wdata <= '0;
            vld_p1          <= 1'b0;
            addr_p1         <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            rsp_addr        <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // p1: BRAM is producing data for the read issued last cycle
            vld_p1  <= dmem_prog_en && !dmem_prog_we;
            addr_p1 <= dmem_prog_addr;

            // p2: capture read data; response fields hold between strobes
            rsp_valid <= vld_p1;
            if (vld_p1) begin
                rsp_data <= dmem_prog_rdata;
                rsp_addr <= addr_p1;
            end

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (accept) begin
                        if (!cmd_legal(cmd_op, cmd_len)) begin
                            err <= 1'b1;
                        end else begin
                            busy            <= 1'b1;
                            dmem_prog_en    <= 1'b1;
                            dmem_prog_we    <= (cmd_op != OP_READ);
                            dmem_prog_addr  <= cmd_addr;
                            dmem_prog_wdata <= (cmd_op != OP_READ) ? cmd_wdata : '0;
                            remain          <= (cmd_op == OP_WRITE) ? '0 : cmd_len - LEN_WIDTH'(1);
                            case (cmd_op)
                                OP_WRITE: state <= WRITE;
                                OP_FILL:  state <= FILL;
                                default:  state <= READ;
                            endcase
                        end
                    end
                end
                WRITE, FILL: begin
                    if (remain != '0) begin
                        dmem_prog_addr <= dmem_prog_addr + ADDR_WIDTH'(1);
                        remain         <= remain - LEN_WIDTH'(1);
                    end else begin
                        dmem_prog_en    <= 1'b0;
                        dmem_prog_we    <= 1'b0;
                        dmem_prog_addr  <= '0;
                        dmem_prog_wdata <= '0;
                        done            <= 1'b1;
                        state           <= IDLE;
                    end
                end
                READ: begin
                    if (remain != '0) begin
                        dmem_prog_addr <= dmem_prog_addr + ADDR_WIDTH'(1);
                        remain         <= remain - LEN_WIDTH'(1);
                    end else begin
                        dmem_prog_en   <= 1'b0;
                        dmem_prog_addr <= '0;
                        state          <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last read's response lands on the same edge as done.
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_host_ctrl.sv
// Bench for dmem_host_ctrl: BRAM model on port B plus a word-level reference memory
// that predicts write sequences, read responses and completion timing.
module tb_dmem_host_ctrl;
    localparam int AW = 8;
    localparam int DW = 64;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          reset, pipe_active, cmd_valid, cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, busy, done, err;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          dmem_prog_en, dmem_prog_we;
    logic [AW-1:0] dmem_prog_addr;
    logic [DW-1:0] dmem_prog_wdata, dmem_prog_rdata;

    int errors = 0;
    int checks = 0;

    dmem_host_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .pipe_active(pipe_active),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr),
        .busy(busy), .done(done), .err(err),
        .dmem_prog_en(dmem_prog_en), .dmem_prog_we(dmem_prog_we),
        .dmem_prog_addr(dmem_prog_addr), .dmem_prog_wdata(dmem_prog_wdata),
        .dmem_prog_rdata(dmem_prog_rdata)
    );

    always #5 clk = ~clk;

    // Port B BRAM with one cycle of read latency
    logic [DW-1:0] bram [256];
    always @(posedge clk) begin
        if (dmem_prog_en) begin
            if (dmem_prog_we) bram[dmem_prog_addr] <= dmem_prog_wdata;
            else              dmem_prog_rdata <= bram[dmem_prog_addr];
        end
    end

    logic [DW-1:0] ref_mem [256];

    // Per-command observations, cycle 1 = first cycle after acceptance
    int            acc_cyc[$];
    logic [AW-1:0] acc_addr[$];
    bit            acc_we[$];
    logic [DW-1:0] acc_wdata[$];
    int            rsp_cyc[$];
    logic [AW-1:0] rsp_a[$];
    logic [DW-1:0] rsp_d[$];
    int            done_cnt, done_cyc, err_cnt, err_cyc, busy_cnt;
    bit            timed_out;

    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [LW-1:0] n,
                           input logic [DW-1:0] d, input int pa_cyc);
        int k;
        int tail;
        bit fin;
        acc_cyc.delete(); acc_addr.delete(); acc_we.delete(); acc_wdata.delete();
        rsp_cyc.delete(); rsp_a.delete(); rsp_d.delete();
        done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1; busy_cnt = 0; timed_out = 0;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            timed_out = 1;
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = n; cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1; fin = 0; tail = 0;
        while (k <= 700 && tail < 3) begin
            if (k == pa_cyc) pipe_active = 1'b1;
            if (fin) tail++;
            if (dmem_prog_en) begin
                acc_cyc.push_back(k); acc_addr.push_back(dmem_prog_addr);
                acc_we.push_back(dmem_prog_we); acc_wdata.push_back(dmem_prog_wdata);
            end
            if (rsp_valid) begin
                rsp_cyc.push_back(k); rsp_a.push_back(rsp_addr); rsp_d.push_back(rsp_data);
            end
            if (done) begin done_cnt++; done_cyc = k; end
            if (err)  begin err_cnt++;  err_cyc = k;  end
            if (busy) busy_cnt++;
            if (done || err) fin = 1;
            @(negedge clk);
            k++;
        end
        if (!fin) timed_out = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; pipe_active = 1'b0; cmd_valid = 1'b0;
        cmd_op = '0; cmd_addr = '0; cmd_len = '0; cmd_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cmd_ready, rsp_valid, busy, done, err, dmem_prog_en, dmem_prog_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {cmd_ready, rsp_valid, busy, done, err, dmem_prog_en, dmem_prog_we});
        end
        checks++;
        if ({rsp_data, rsp_addr, dmem_prog_addr, dmem_prog_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got rsp_data=%h rsp_addr=%h addr=%h wdata=%h want 0",
                     rsp_data, rsp_addr, dmem_prog_addr, dmem_prog_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_read();
        run_cmd(2'd1, 8'h10, 9'd0, 64'hDEADBEEF, 0);
        checks++;
        if (timed_out || acc_addr.size() != 1) begin
            errors++;
            $display("FAIL wr_count: got %0d accesses (timeout=%0d) want 1", acc_addr.size(), timed_out);
        end else begin
            checks++;
            if (acc_addr[0] !== 8'h10 || acc_we[0] !== 1'b1 || acc_wdata[0] !== 64'hDEADBEEF || acc_cyc[0] != 1) begin
                errors++;
                $display("FAIL wr_access: got addr=%h we=%b data=%h cyc=%0d want 10 1 deadbeef 1",
                         acc_addr[0], acc_we[0], acc_wdata[0], acc_cyc[0]);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 2 || busy_cnt != 2) begin
            errors++;
            $display("FAIL wr_done: got done=%0d@%0d busy=%0d want 1@2 busy=2", done_cnt, done_cyc, busy_cnt);
        end
        ref_mem[8'h10] = 64'hDEADBEEF;

        run_cmd(2'd0, 8'h10, 9'd1, '0, 0);
        checks++;
        if (rsp_d.size() != 1) begin
            errors++;
            $display("FAIL rd1_count: got %0d responses want 1", rsp_d.size());
        end else begin
            checks++;
            if (rsp_d[0] !== 64'hDEADBEEF || rsp_a[0] !== 8'h10 || rsp_cyc[0] != 3 || done_cyc != 3) begin
                errors++;
                $display("FAIL rd1_rsp: got data=%h addr=%h cyc=%0d done@%0d want deadbeef 10 3 3",
                         rsp_d[0], rsp_a[0], rsp_cyc[0], done_cyc);
            end
        end
    endtask

    task automatic test_fill_wrap();
        logic [AW-1:0] exp_a [4];
        int bad;
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        run_cmd(2'd2, 8'hFE, 9'd4, 64'h5, 0);
        bad = 0;
        if (acc_addr.size() != 4) bad = 99;
        else for (int i = 0; i < 4; i++)
            if (acc_addr[i] !== exp_a[i] || acc_we[i] !== 1'b1 || acc_wdata[i] !== 64'h5 || acc_cyc[i] != i + 1) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fill_wrap_seq: got %0d bad accesses of %0d want 0 bad of 4", bad, acc_addr.size());
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 5 || busy_cnt != 5) begin
            errors++;
            $display("FAIL fill_wrap_done: got done=%0d@%0d busy=%0d want 1@5 busy=5", done_cnt, done_cyc, busy_cnt);
        end
        for (int i = 0; i < 4; i++) ref_mem[exp_a[i]] = 64'h5;

        run_cmd(2'd0, 8'hFE, 9'd4, '0, 0);
        bad = 0;
        if (rsp_d.size() != 4) bad = 99;
        else for (int i = 0; i < 4; i++)
            if (rsp_d[i] !== ref_mem[exp_a[i]] || rsp_a[i] !== exp_a[i] || rsp_cyc[i] != i + 3) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rd_wrap_rsp: got %0d bad responses of %0d want 0 bad of 4", bad, rsp_d.size());
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 6 || busy_cnt != 6) begin
            errors++;
            $display("FAIL rd_wrap_done: got done=%0d@%0d busy=%0d want 1@6 busy=6", done_cnt, done_cyc, busy_cnt);
        end
    endtask

    task automatic test_pipe_active();
        int hits;
        hits = 0;
        pipe_active = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 8'h33; cmd_wdata = 64'h1234;
        repeat (6) begin
            @(negedge clk);
            if (cmd_ready || dmem_prog_en || busy || done) hits++;
        end
        cmd_valid = 1'b0;
        pipe_active = 1'b0;
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL pipe_block: got %0d active cycles want 0", hits);
        end
        @(negedge clk);
        run_cmd(2'd2, 8'h80, 9'd8, 64'hA5A5, 3);
        checks++;
        if (acc_addr.size() != 8 || done_cnt != 1 || done_cyc != 9) begin
            errors++;
            $display("FAIL pipe_fill: got %0d writes done=%0d@%0d want 8 writes done=1@9",
                     acc_addr.size(), done_cnt, done_cyc);
        end
        for (int i = 0; i < 8; i++) ref_mem[AW'(8'h80 + i)] = 64'hA5A5;
        pipe_active = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_illegal();
        logic [1:0]    ops [3];
        logic [LW-1:0] lens [3];
        ops[0] = 2'd3; lens[0] = 9'd4;
        ops[1] = 2'd0; lens[1] = 9'd0;
        ops[2] = 2'd0; lens[2] = 9'd300;
        for (int i = 0; i < 3; i++) begin
            run_cmd(ops[i], 8'h20, lens[i], 64'h77, 0);
            checks++;
            if (err_cnt != 1 || err_cyc != 1 || acc_addr.size() != 0 || done_cnt != 0 || busy_cnt != 0) begin
                errors++;
                $display("FAIL illegal_%0d: got err=%0d@%0d acc=%0d done=%0d busy=%0d want 1@1 0 0 0",
                         i, err_cnt, err_cyc, acc_addr.size(), done_cnt, busy_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]    op;
        logic [AW-1:0] a, ea;
        logic [LW-1:0] n;
        logic [DW-1:0] d;
        int            exp_n, exp_done, bad;
        int            seen [256];
        for (int t = 0; t < 40; t++) begin
            if (t == 0)       begin op = 2'd2; n = 9'd256; end
            else if (t == 20) begin op = 2'd0; n = 9'd256; end
            else begin op = 2'($urandom_range(0, 2)); n = LW'($urandom_range(1, 24)); end
            a = AW'($urandom);
            d = {$urandom, $urandom};
            run_cmd(op, a, n, d, 0);
            exp_n    = (op == 2'd1) ? 1 : int'(n);
            exp_done = (op == 2'd1) ? 2 : (op == 2'd2) ? int'(n) + 1 : int'(n) + 2;
            bad = 0;
            if (acc_addr.size() != exp_n) bad = 999;
            else for (int i = 0; i < exp_n; i++) begin
                ea = a + AW'(i);
                if (acc_addr[i] !== ea || acc_we[i] !== (op != 2'd0) || acc_cyc[i] != i + 1 ||
                    (op != 2'd0 && acc_wdata[i] !== d)) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand%0d_acc: op=%0d got %0d bad of %0d accesses want 0 bad of %0d",
                         t, op, bad, acc_addr.size(), exp_n);
            end
            if (op == 2'd0) begin
                bad = 0;
                if (rsp_d.size() != exp_n) bad = 999;
                else for (int i = 0; i < exp_n; i++) begin
                    ea = a + AW'(i);
                    if (rsp_d[i] !== ref_mem[ea] || rsp_a[i] !== ea || rsp_cyc[i] != i + 3) bad++;
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL rand%0d_rsp: got %0d bad of %0d responses want 0 bad of %0d",
                             t, bad, rsp_d.size(), exp_n);
                end
            end else begin
                for (int i = 0; i < exp_n; i++) ref_mem[AW'(a + AW'(i))] = d;
            end
            checks++;
            if (timed_out || done_cnt != 1 || done_cyc != exp_done || err_cnt != 0 || busy_cnt != exp_done) begin
                errors++;
                $display("FAIL rand%0d_done: got done=%0d@%0d err=%0d busy=%0d to=%0d want 1@%0d 0 %0d",
                         t, done_cnt, done_cyc, err_cnt, busy_cnt, timed_out, exp_done, exp_done);
            end
            if (t == 0) begin
                for (int i = 0; i < 256; i++) seen[i] = 0;
                foreach (acc_addr[i]) seen[acc_addr[i]]++;
                bad = 0;
                for (int i = 0; i < 256; i++) if (seen[i] != 1) bad++;
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL fill256_cover: got %0d words not hit exactly once want 0", bad);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int hits;
        hits = 0;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready0: got %b want 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 8'h40; cmd_len = 9'd16;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dmem_prog_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_active: got en=%b busy=%b want 1 1", dmem_prog_en, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem_prog_en, rsp_valid, busy, done, cmd_ready} !== 5'b0) begin
            errors++;
            $display("FAIL midrst_abort: got en,rsp,busy,done,ready=%b want 00000",
                     {dmem_prog_en, rsp_valid, busy, done, cmd_ready});
        end
        repeat (2) begin
            @(negedge clk);
            if (dmem_prog_en || rsp_valid || done || busy) hits++;
        end
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (dmem_prog_en || rsp_valid || done || busy) hits++;
        end
        checks++;
        if (hits != 0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_after: got %0d active cycles ready=%b want 0 1", hits, cmd_ready);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_fill_wrap();
        test_pipe_active();
        test_illegal();
        test_random();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
